// File: rtl/hs_rr_arbiter_if.sv
// Bundle of the N sender-side 4-phase channels, the shared receiver channel and the status outputs.
// The arbiter itself connects through the slave modport. The environment that drives it uses the master modport.
interface hs_rr_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    // 4-phase handshake on both sides:
    // - req rises, then ack rises, then req falls, then ack falls, in that order.
    // - Data belongs to the side raising req and must be valid when req rises.
    logic                 en;
    logic [N-1:0]         s_req;
    logic [N*WIDTH-1:0]   s_data;
    logic [N-1:0]         s_ack;
    logic                 m_req;
    logic                 m_ack;
    logic [WIDTH-1:0]     m_data;
    logic [IW-1:0]        grant_id;
    logic                 busy;
    logic                 err;

    modport master (
        output en, s_req, s_data, m_ack,
        input  s_ack, m_req, m_data, grant_id, busy, err
    );

    modport slave (
        input  en, s_req, s_data, m_ack,
        output s_ack, m_req, m_data, grant_id, busy, err
    );
endinterface

// File: rtl/hs_rr_arbiter.sv
// Round-robin arbiter sharing one 4-phase handshake receiver between N senders.
// The grant is held until both the sender side and the receiver side have closed the full 4-phase cycle.
module hs_rr_arbiter #(
    parameter int N      = 4,
    parameter int WIDTH  = 8,
    parameter int TO_CYC = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    hs_rr_arbiter_if.slave       bus,
    output logic [2:0]           fsm_state
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam bit TO_EN = (TO_CYC != 0);
    localparam logic [CW-1:0] TO_LAST = CW'((TO_CYC > 0) ? TO_CYC - 1 : 0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        ACK   = 3'd2,
        REL   = 3'd3,
        ABORT = 3'd4
    } state_t;

    state_t            state;
    logic [IW-1:0]     ptr;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  data_arr [N];
    logic              found;
    logic [IW-1:0]     win;
    logic [IW-1:0]     sel;
    logic [IW-1:0]     next_ptr;
    logic [N-1:0]      grant_onehot;
    int                idx;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign data_arr[i] = bus.s_data[i*WIDTH +: WIDTH];
    end

    // The search runs from ptr+N-1 down to ptr, so the entry nearest ptr is written last and wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        sel   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            sel = IW'(idx);
            if (bus.s_req[sel]) begin
                found = 1'b1;
                win   = sel;
            end
        end
    end

    assign next_ptr     = (bus.grant_id == IW'(N - 1)) ? '0 : bus.grant_id + IW'(1);
    assign grant_onehot = {{(N-1){1'b0}}, 1'b1} << bus.grant_id;
    assign fsm_state    = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            cnt          <= '0;
            bus.m_req    <= 1'b0;
            bus.s_ack    <= '0;
            bus.m_data   <= '0;
            bus.grant_id <= '0;
            bus.busy     <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            bus.err <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en && found) begin
                        state        <= REQ;
                        bus.m_req    <= 1'b1;
                        bus.m_data   <= data_arr[win];
                        bus.grant_id <= win;
                        bus.busy     <= 1'b1;
                        cnt          <= '0;
                    end
                end
                REQ: begin
                    // A receiver ack takes priority over a timeout that expires on the same edge.
                    if (bus.m_ack) begin
                        state     <= ACK;
                        bus.s_ack <= grant_onehot;
                    end else if (TO_EN && cnt == TO_LAST) begin
                        state     <= ABORT;
                        bus.m_req <= 1'b0;
                        bus.err   <= 1'b1;
                    end else if (TO_EN) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ACK: begin
                    if (!bus.s_req[bus.grant_id]) begin
                        state     <= REL;
                        bus.m_req <= 1'b0;
                    end
                end
                REL: begin
                    if (!bus.m_ack) begin
                        state     <= IDLE;
                        bus.s_ack <= '0;
                        bus.busy  <= 1'b0;
                        ptr       <= next_ptr;
                    end
                end
                ABORT: begin
                    // Wait for a late ack to fall so the receiver is idle before the next grant.
                    if (!bus.m_ack) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                        ptr      <= next_ptr;
                    end
                end
                default: begin
                    state     <= IDLE;
                    bus.m_req <= 1'b0;
                    bus.s_ack <= '0;
                    bus.busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Directed and randomized bench for hs_rr_arbiter.
// It uses a round-robin reference model and a queue of expected grants.
module tb_hs_rr_arbiter;
    localparam int N      = 4;
    localparam int WIDTH  = 8;
    localparam int TO_CYC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] fsm_state;

    always #5 clk = ~clk;

    hs_rr_arbiter_if #(.N(N), .WIDTH(WIDTH)) bus ();

    hs_rr_arbiter #(.N(N), .WIDTH(WIDTH), .TO_CYC(TO_CYC)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    int               errors    = 0;
    int               checks    = 0;
    int               model_ptr = 0;
    logic [WIDTH-1:0] data_m [N];
    logic [1:0]       exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int rr_pick(input int p, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic drive_req(input logic [N-1:0] r, input int d0);
        for (int i = 0; i < N; i++) begin
            data_m[i] = WIDTH'($urandom_range(0, 255));
            if (i == 0 && d0 >= 0) data_m[i] = WIDTH'(d0);
            bus.s_data[i*WIDTH +: WIDTH] = data_m[i];
        end
        bus.s_req = r;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_m_req"}, 32'(bus.m_req), 32'd0);
        chk({tag, "_s_ack"}, 32'(bus.s_ack), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    // One complete 4-phase transaction. The receiver acks after wait_cyc extra cycles in REQ.
    task automatic run_txn(input logic [N-1:0] r, input int wait_cyc, input bit drop_en, input int d0);
        int               g;
        logic [1:0]       eg;
        logic [WIDTH-1:0] gd;
        drive_req(r, d0);
        g = rr_pick(model_ptr, r);
        exp_q.push_back(2'(g));
        gd = data_m[g];
        step();
        eg = exp_q.pop_front();
        chk("grant_id", 32'(bus.grant_id), 32'(eg));
        chk("m_req_rise", 32'(bus.m_req), 32'd1);
        chk("m_data", 32'(bus.m_data), 32'(gd));
        chk("s_ack_in_req", 32'(bus.s_ack), 32'd0);
        chk("busy_in_req", 32'(bus.busy), 32'd1);
        bus.s_data = (N*WIDTH)'($urandom);
        repeat (wait_cyc) step();
        bus.m_ack = 1'b1;
        step();
        chk("s_ack_rise", 32'(bus.s_ack), 32'(1 << g));
        chk("m_req_in_ack", 32'(bus.m_req), 32'd1);
        chk("m_data_stable", 32'(bus.m_data), 32'(gd));
        chk("err_quiet", 32'(bus.err), 32'd0);
        if (drop_en) bus.en = 1'b0;
        bus.s_req[g] = 1'b0;
        step();
        chk("m_req_fall", 32'(bus.m_req), 32'd0);
        chk("s_ack_in_rel", 32'(bus.s_ack), 32'(1 << g));
        bus.m_ack = 1'b0;
        step();
        chk("s_ack_fall", 32'(bus.s_ack), 32'd0);
        chk("busy_done", 32'(bus.busy), 32'd0);
        chk("grant_id_hold", 32'(bus.grant_id), 32'(eg));
        model_ptr = (g + 1) % N;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_ptr = 0;
    endtask

    initial begin : main
        int g;
        rst        = 1'b1;
        bus.en     = 1'b0;
        bus.s_req  = '0;
        bus.s_data = '0;
        bus.m_ack  = 1'b0;
        step();
        step();
        check_idle("reset");
        chk("reset_err", 32'(bus.err), 32'd0);
        chk("reset_grant_id", 32'(bus.grant_id), 32'd0);
        chk("reset_m_data", 32'(bus.m_data), 32'd0);
        rst    = 1'b0;
        bus.en = 1'b1;
        step();
        check_idle("no_req");

        // Single sender, data A5, ack two cycles after m_req.
        run_txn(4'b0001, 1, 1'b0, 8'hA5);

        // Fairness with all senders requesting, starting from pointer 0.
        do_reset();
        for (int t = 0; t < 5; t++) run_txn(4'b1111, t % 3, 1'b0, -1);

        // Wrap and skip: move the pointer to 3, then requests 0101 give 0, then 2.
        run_txn(4'b0100, 0, 1'b0, -1);
        run_txn(4'b0101, 0, 1'b0, -1);
        run_txn(4'b0100, 0, 1'b0, -1);
        run_txn(4'b1111, 0, 1'b0, -1);

        // Sender drops req during REQ, and other senders toggle. The FSM still waits for m_ack.
        drive_req(4'b0010, -1);
        g = rr_pick(model_ptr, 4'b0010);
        step();
        chk("viol_grant", 32'(bus.grant_id), 32'(g));
        bus.s_req = 4'b1101;
        step();
        step();
        chk("viol_m_req_held", 32'(bus.m_req), 32'd1);
        chk("viol_busy", 32'(bus.busy), 32'd1);
        chk("viol_grant_stable", 32'(bus.grant_id), 32'(g));
        bus.m_ack = 1'b1;
        step();
        chk("viol_s_ack", 32'(bus.s_ack), 32'(1 << g));
        step();
        chk("viol_rel", 32'(bus.m_req), 32'd0);
        bus.m_ack = 1'b0;
        bus.s_req = '0;
        step();
        check_idle("viol_idle");
        model_ptr = (g + 1) % N;

        // Timeout: m_ack held low for TO_CYC cycles, then a late ack arrives during ABORT.
        drive_req(4'b0001, -1);
        g = rr_pick(model_ptr, 4'b0001);
        step();
        for (int c = 0; c < TO_CYC; c++) begin
            chk("to_m_req", 32'(bus.m_req), 32'd1);
            chk("to_err_low", 32'(bus.err), 32'd0);
            if (c < TO_CYC - 1) step();
        end
        step();
        chk("to_err_pulse", 32'(bus.err), 32'd1);
        chk("to_abort_m_req", 32'(bus.m_req), 32'd0);
        chk("to_abort_s_ack", 32'(bus.s_ack), 32'd0);
        chk("to_abort_busy", 32'(bus.busy), 32'd1);
        bus.s_req = '0;
        bus.m_ack = 1'b1;
        step();
        chk("to_err_single", 32'(bus.err), 32'd0);
        chk("to_wait_ack_low", 32'(bus.busy), 32'd1);
        bus.m_ack = 1'b0;
        step();
        check_idle("to_idle");
        model_ptr = (g + 1) % N;
        run_txn(4'b1111, 0, 1'b0, -1);

        // en dropped in ACK: the transaction completes, and no new grant is made until en returns.
        run_txn(4'b0100, 1, 1'b1, -1);
        bus.s_req = 4'b0010;
        repeat (3) step();
        check_idle("en_low_hold");
        bus.en = 1'b1;
        run_txn(4'b0010, 0, 1'b0, -1);

        // Reset while in ACK.
        drive_req(4'b0100, -1);
        step();
        bus.m_ack = 1'b1;
        step();
        chk("rst_pre_s_ack", 32'(bus.s_ack), 32'(4'b0100));
        rst = 1'b1;
        step();
        check_idle("rst_mid");
        chk("rst_mid_grant_id", 32'(bus.grant_id), 32'd0);
        chk("rst_mid_m_data", 32'(bus.m_data), 32'd0);
        rst       = 1'b0;
        bus.m_ack = 1'b0;
        model_ptr = 0;
        run_txn(4'b0010, 0, 1'b0, -1);

        // Randomized traffic against the model.
        for (int t = 0; t < 24; t++) begin
            run_txn(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, TO_CYC - 2), 1'b0, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
